// File: rtl/data_memory_responder.sv
// Data-memory responder: valid/ready load/store slave over a doubleword array with a fixed wait.
// Optional alignment fault checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_memory_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_address,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;

  logic [63:0] mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [2:0]       lane;
  logic [5:0]       shamt;
  logic             out_of_range;
  logic             misaligned;
  logic             access_err;
  logic [63:0]      cur_word;
  logic [63:0]      field_mask;
  logic [63:0]      field;
  logic             field_sign;
  logic [63:0]      load_val;
  logic [7:0]       be_base;
  logic [15:0]      be_wide;
  logic [7:0]       byte_en;
  logic [63:0]      wshift;
  logic [63:0]      merged;
  logic             exec_access;
  logic             mem_we;

  assign idx          = addr_q[IDX_W+2:3];
  assign lane         = addr_q[2:0];
  assign shamt        = {lane, 3'b000};
  assign out_of_range = (addr_q >> (IDX_W + 3)) != 64'd0;

`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (size_q)
      2'd1:    misaligned = lane[0];
      2'd2:    misaligned = |lane[1:0];
      2'd3:    misaligned = |lane;
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign access_err = out_of_range | misaligned;
  assign cur_word   = mem[idx];

  always_comb begin
    field_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    be_base    = 8'hFF;
    case (size_q)
      2'd0:    begin field_mask = 64'h0000_0000_0000_00FF; be_base = 8'h01; end
      2'd1:    begin field_mask = 64'h0000_0000_0000_FFFF; be_base = 8'h03; end
      2'd2:    begin field_mask = 64'h0000_0000_FFFF_FFFF; be_base = 8'h0F; end
      default: begin field_mask = 64'hFFFF_FFFF_FFFF_FFFF; be_base = 8'hFF; end
    endcase
  end

  // Right-shifting brings in zeros, so bytes past the doubleword edge read as 0 before extension.
  assign field = (cur_word >> shamt) & field_mask;

  always_comb begin
    field_sign = 1'b0;
    case (size_q)
      2'd0:    field_sign = field[7];
      2'd1:    field_sign = field[15];
      2'd2:    field_sign = field[31];
      default: field_sign = 1'b0;
    endcase
  end

  assign load_val = (!unsigned_q && field_sign) ? (field | ~field_mask) : field;

  // Enables shifted out past byte 7 are dropped, truncating stores at the doubleword edge.
  assign be_wide = {8'h00, be_base} << lane;
  assign byte_en = be_wide[7:0];
  assign wshift  = wdata_q << shamt;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = byte_en[gi] ? wshift[gi*8 +: 8] : cur_word[gi*8 +: 8];
    end
  endgenerate

  assign exec_access = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_we      = exec_access && write_q && !access_err;

  always_ff @(posedge clock) begin
    if (mem_we) mem[idx] <= merged;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    case (state_q)
      IDLE: begin
        if (req_ready_q && req_valid) begin
          write_d     = req_write;
          addr_d      = req_address;
          wdata_d     = req_wdata;
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          req_ready_d = 1'b0;
          // WAIT always takes at least one cycle, so the response rises LATENCY+1 edges after accept.
          cnt_d       = 4'(LATENCY);
          state_d     = WAIT;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESPOND;
          resp_valid_d = 1'b1;
          resp_error_d = access_err;
          resp_rdata_d = (write_q || access_err) ? 64'd0 : load_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPOND: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = 64'd0;
          resp_error_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_error_q <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed steps plus random traffic against a byte-array model.
module tb_data_memory_responder;
  localparam int DEPTH   = 512;
  localparam int LATENCY = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_address = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_error;

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [DEPTH*8];

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, fields assembled little-endian byte by byte.
  function automatic void model_access(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                                       input logic [1:0] size, input logic uns,
                                       output logic [63:0] rdata, output logic err);
    int n;
    int lane;
    int base;
    n     = 1 << size;
    lane  = int'(addr % 64'd8);
    err   = (addr >= 64'(DEPTH * 8));
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((addr % 64'(n)) != 64'd0) err = 1'b1;
`endif
    rdata = 64'd0;
    if (err) return;
    base = int'(addr[31:0]) - lane;
    for (int i = 0; i < n; i++) begin
      if (lane + i < 8) begin
        if (wr) mm[base + lane + i] = wdata[8*i +: 8];
        else    rdata[8*i +: 8] = mm[base + lane + i];
      end
    end
    if (wr) rdata = 64'd0;
    else if (!uns && n < 8 && rdata[8*n-1])
      for (int j = n; j < 8; j++) rdata[8*j +: 8] = 8'hFF;
  endfunction

  task automatic do_txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic uns, input int stall,
                        output logic [63:0] obs_rdata, output logic obs_err);
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          t;
    int          k;
    logic        got;
    model_access(wr, addr, wdata, size, uns, exp_rdata, exp_err);
    obs_rdata = 64'hX;
    obs_err   = 1'bX;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_address = addr;
    req_wdata = wdata; req_size = size; req_unsigned = uns;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk("accept_timeout", 64'(t < 50), 64'd1);
    if (t >= 50) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = $urandom_range(0, 1) == 1;
    req_address = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_size = 2'($urandom_range(0, 3));
    chk("ready_after_accept", 64'(req_ready), 64'd0);
    k = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(posedge clock);
      #1;
      k++;
      got = resp_valid;
    end
    chk("latency", 64'(k), 64'(LATENCY + 1));
    obs_rdata = resp_rdata;
    obs_err   = resp_error;
    $display("txn wr=%0d addr=%h size=%0d uns=%0d wdata=%h -> rdata=%h err=%0d", wr, addr, size, uns,
             wdata, obs_rdata, obs_err);
    chk("rdata", resp_rdata, exp_rdata);
    chk("error", 64'(resp_error), 64'(exp_err));
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      req_valid = 1'b1;
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_rdata", resp_rdata, obs_rdata);
      chk("stall_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clock);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    chk("hs_valid_clr", 64'(resp_valid), 64'd0);
    chk("hs_rdata_clr", resp_rdata, 64'd0);
    chk("hs_ready_set", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [63:0] a;
    logic [63:0] loc0;
    logic [63:0] loc80;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_error", 64'(resp_error), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("ready_before_edge", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1;
    chk("ready_first_edge", 64'(req_ready), 64'd1);

    // Preset the region used by random traffic
    for (int i = 0; i < 18; i++)
      do_txn(1'b1, 64'(i * 8), {$urandom, $urandom}, 2'd3, 1'b0, 0, rd, er);

    // Doubleword store/load
    do_txn(1'b1, 64'h40, 64'h1122334455667788, 2'd3, 1'b0, 0, rd, er);
    chk("dw_store_rdata", rd, 64'd0);
    do_txn(1'b0, 64'h40, 64'd0, 2'd3, 1'b0, 0, rd, er);
    chk("dw_load", rd, 64'h1122334455667788);

    // Byte merge and extension
    do_txn(1'b1, 64'h43, 64'h00000000000000F0, 2'd0, 1'b0, 0, rd, er);
    do_txn(1'b0, 64'h40, 64'd0, 2'd3, 1'b0, 0, rd, er);
    chk("merge_dw", rd, 64'h11223344F0667788);
    do_txn(1'b0, 64'h43, 64'd0, 2'd0, 1'b0, 0, rd, er);
    chk("byte_signed", rd, 64'hFFFFFFFFFFFFFFF0);
    do_txn(1'b0, 64'h43, 64'd0, 2'd0, 1'b1, 0, rd, er);
    chk("byte_unsigned", rd, 64'h00000000000000F0);

    // Back-pressure with a competing request held
    do_txn(1'b0, 64'h40, 64'd0, 2'd3, 1'b0, 5, rd, er);
    chk("bp_rdata", rd, 64'h11223344F0667788);

    // Out of range
    do_txn(1'b0, 64'h1000, 64'd0, 2'd3, 1'b0, 0, rd, er);
    chk("oob_load_err", 64'(er), 64'd1);
    chk("oob_load_rdata", rd, 64'd0);
    do_txn(1'b0, 64'h0, 64'd0, 2'd3, 1'b0, 0, loc0, er);
    do_txn(1'b1, 64'h1000, 64'hDEAD, 2'd3, 1'b0, 0, rd, er);
    chk("oob_store_err", 64'(er), 64'd1);
    do_txn(1'b0, 64'h0, 64'd0, 2'd3, 1'b0, 0, rd, er);
    chk("oob_loc0_kept", rd, loc0);

    // Reset one cycle after accepting a store
    do_txn(1'b0, 64'h80, 64'd0, 2'd3, 1'b0, 0, loc80, er);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_address = 64'h80;
    req_wdata = 64'hAAAA; req_size = 2'd3; req_unsigned = 1'b0;
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("async_req_ready", 64'(req_ready), 64'd0);
    chk("async_resp_valid", 64'(resp_valid), 64'd0);
    chk("async_resp_rdata", resp_rdata, 64'd0);
    chk("async_resp_error", 64'(resp_error), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_release_ready", 64'(req_ready), 64'd1);
    do_txn(1'b0, 64'h80, 64'd0, 2'd3, 1'b0, 0, rd, er);
    chk("rst_store_lost", rd, loc80);

    // Misaligned word
    do_txn(1'b0, 64'h42, 64'd0, 2'd2, 1'b0, 0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("misalign_err", 64'(er), 64'd1);
    chk("misalign_rdata", rd, 64'd0);
`else
    chk("misalign_err", 64'(er), 64'd0);
    chk("misalign_rdata", rd, 64'h000000003344F066);
`endif

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = 64'h1000 + 64'($urandom_range(0, 4095));
      else a = 64'($urandom_range(0, 16'h8F));
      do_txn($urandom_range(0, 1) == 1, a, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, int'($urandom_range(0, 2)), rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
